seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Sequential shift-add signed multiplier; immediate upstream feeder of the LED output stage.
//  Takes two two's-complement operands on a start request.
//  Produces a sign-magnitude result: unsigned magnitude o_product, separate o_sign, and a held o_stop.
//  The LED stage displays {o_sign, o_product} only while o_stop is high.
//  One product per start; operation is non-pipelined.
// PARAMETERS
//  DW   8       operand width in bits (two's complement)
//  D2W  2*DW    product magnitude width; must equal pkg_mult D2W (product_t width)
// PORTS
//  clk             in   1    system clock, rising-edge active
//  rst             in   1    asynchronous, active-high reset
//  i_start         in   1    start request, sampled on clk rising edge
//  i_multiplicand  in   DW   signed operand A, captured when start accepted
//  i_multiplier    in   DW   signed operand B, captured when start accepted
//  o_product       out  D2W  unsigned magnitude |A*B|, valid while o_stop=1
//  o_sign          out  1    result sign (1 = negative), valid while o_stop=1
//  o_stop          out  1    result-valid level; held until next accepted start or reset
//  o_busy          out  1    high in LOAD/MULT; start is ignored while high
// BEHAVIOUR
//  Reset (async, rst=1)
//   - state=IDLE; o_product=0, o_sign=0, o_stop=0, o_busy=0; all internal registers 0.
//  All outputs are registered; there is no combinational path from inputs to outputs.
//  FSM states: IDLE, LOAD, MULT, DONE.
//  IDLE
//   - On i_start=1 (edge k): capture A and B; go to LOAD.
//  LOAD (edge k+1)
//   - magA=|A|, magB=|B| as DW-bit unsigned (-2^(DW-1) maps to 2^(DW-1)).
//   - sign_r = A[DW-1] ^ B[DW-1].
//   - acc=0, cnt=0; go to MULT.
//  MULT, one iteration per edge, DW iterations:
//   - If magB[0]: acc += magA << cnt (D2W bits, never overflows).
//   - magB >>= 1; cnt++.
//   - The edge performing iteration cnt=DW-1 loads o_product=final acc, loads o_sign, sets o_stop=1, and goes to DONE.
//  Sign of a zero product
//   - If the final magnitude is 0, o_sign=0. No negative zero is ever output.
//  Latency
//   - o_stop rises on edge k+DW+1 (k = start-sampling edge); k+9 for DW=8.
//  o_busy
//   - 1 from edge k through edge k+DW+1 exclusive, i.e. while in LOAD or MULT.
//  o_product and o_sign outside DONE
//   - Held at 0 whenever not in DONE, so the LED stage sees clean zeros while busy.
//  DONE
//   - Outputs hold indefinitely.
//   - On i_start=1: capture new operands; clear o_stop, o_product and o_sign on that same edge; go to LOAD.
//  Start while busy
//   - i_start in LOAD or MULT is ignored; the operation in flight completes unchanged.
//  Operand stability
//   - Operand inputs may change freely after the capture edge; only captured values are used.
//  Reset mid-operation
//   - Immediate return to IDLE with reset values; the partial result is discarded and o_stop is never raised.
//  i_start held high
//   - In IDLE/DONE, a continuously high i_start restarts on every accept, so o_stop pulses for 1 cycle per product.
// TESTING
//  1. Reset then A=5, B=-3, start pulse
//     -> o_stop=1 exactly 9 edges later; o_product=15, o_sign=1; o_busy=0 in DONE.
//  2. A=-128, B=-128
//     -> o_product=16384, o_sign=0.
//     A=127, B=-128 -> o_product=16256, o_sign=1.
//  3. A=0, B=-7
//     -> o_product=0, o_sign=0 (no negative zero).
//     A=-1, B=-1 -> o_product=1, o_sign=0.
//  4. A=12, B=10 start; re-assert start with A=3, B=3 at edge k+4
//     -> ignored; result 120, sign 0 at k+9.
//     Then start A=3, B=3 -> o_stop drops next edge; result 9 at +9.
//  5. A=100, B=100 start; assert rst at edge k+5
//     -> all outputs 0 immediately, state IDLE, no o_stop.
//     Next start A=2, B=-2 -> 4, sign 1.
//  6. Random: 1000 operand pairs in -128..127, checked against a signed reference model.
//     -> |A*B| and sign match; latency always 9; o_stop held until next start.

Source files
------------

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add signed multiplier with sign-magnitude result
module seq_multiplier #(
    parameter int DW  = 8,
    parameter int D2W = 2 * DW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [DW-1:0]  i_multiplicand,
    input  logic [DW-1:0]  i_multiplier,
    output logic [D2W-1:0] o_product,
    output logic           o_sign,
    output logic           o_stop,
    output logic           o_busy
);

    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [DW-1:0]  a_r;
    logic [DW-1:0]  b_r;
    logic [DW-1:0]  mag_a;
    logic [DW-1:0]  mag_b;
    logic           sign_r;
    logic [D2W-1:0] acc;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           last_iter;
    logic [D2W-1:0] partial;
    logic [D2W-1:0] acc_sum;

    logic [D2W-1:0] product_next;
    logic           sign_next;
    logic           stop_next;
    logic           busy_next;

    assign accept    = i_start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CW'(DW - 1));
    assign partial   = {{(D2W - DW){1'b0}}, mag_a} << cnt;
    assign acc_sum   = acc + (mag_b[0] ? partial : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = MULT;
            MULT:    if (last_iter) state_next = DONE;
            DONE:    if (accept) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Result outputs are forced to zero everywhere outside DONE so the LED stage never sees stale data.
    always_comb begin
        busy_next    = (state_next == LOAD) || (state_next == MULT);
        stop_next    = (state_next == DONE);
        product_next = '0;
        sign_next    = 1'b0;
        if (state == MULT && last_iter) begin
            product_next = acc_sum;
            sign_next    = sign_r && (acc_sum != '0);
        end else if (state_next == DONE) begin
            product_next = o_product;
            sign_next    = o_sign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_product <= '0;
            o_sign    <= 1'b0;
            o_stop    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_product <= product_next;
            o_sign    <= sign_next;
            o_stop    <= stop_next;
            o_busy    <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sign_r <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                a_r <= i_multiplicand;
                b_r <= i_multiplier;
            end
            if (state == LOAD) begin
                // The most negative value negates to itself, which reads correctly as unsigned.
                mag_a  <= a_r[DW-1] ? (~a_r + 1'b1) : a_r;
                mag_b  <= b_r[DW-1] ? (~b_r + 1'b1) : b_r;
                sign_r <= a_r[DW-1] ^ b_r[DW-1];
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MULT) begin
                acc   <= acc_sum;
                mag_b <= mag_b >> 1;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_multiplicand;
    logic [7:0]  i_multiplier;
    logic [15:0] o_product;
    logic        o_sign;
    logic        o_stop;
    logic        o_busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] sb[$];
    logic [16:0] exp_v;
    int          lat;

    seq_multiplier #(.DW(8), .D2W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_product      (o_product),
        .o_sign         (o_sign),
        .o_stop         (o_stop),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input int a, input int b);
        int p;
        int m;
        p = a * b;
        m = (p < 0) ? -p : p;
        return {(p < 0), m[15:0]};
    endfunction

    task automatic start_op(input int a, input int b);
        i_start        = 1'b1;
        i_multiplicand = a[7:0];
        i_multiplier   = b[7:0];
        @(posedge clk);
        #1;
        i_start        = 1'b0;
        i_multiplicand = 8'($urandom);
        i_multiplier   = 8'($urandom);
    endtask

    task automatic wait_stop(input int lat0, output int l);
        l = lat0;
        while (!o_stop && l < 30) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!o_stop) l = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_start = 1'b0;
        i_multiplicand = '0;
        i_multiplier = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({o_product, o_sign, o_stop, o_busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got prod=%0d sign=%0b stop=%0b busy=%0b, want all 0",
                     o_product, o_sign, o_stop, o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        start_op(5, -3);
        sb.push_back({1'b1, 16'd15});
        n_checks++;
        if (o_busy !== 1'b1 || o_product !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%0b prod=%0d, want busy=1 prod=0", o_busy, o_product);
        end
        wait_stop(0, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want 9", lat);
        end
        exp_v = sb.pop_front();
        n_checks++;
        if ({o_sign, o_product} !== exp_v || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got sign=%0b prod=%0d busy=%0b, want sign=%0b prod=%0d busy=0",
                     o_sign, o_product, o_busy, exp_v[16], exp_v[15:0]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_stop !== 1'b1 || o_product !== 16'd15) begin
            n_fail++;
            $display("FAIL basic_hold: got stop=%0b prod=%0d, want stop=1 prod=15", o_stop, o_product);
        end
    endtask

    task automatic test_extremes;
        int tab_a[4] = '{-128, 127, 0, -1};
        int tab_b[4] = '{-128, -128, -7, -1};
        int tab_p[4] = '{16384, 16256, 0, 1};
        int tab_s[4] = '{0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            start_op(tab_a[i], tab_b[i]);
            sb.push_back({tab_s[i][0], tab_p[i][15:0]});
            wait_stop(0, lat);
            exp_v = sb.pop_front();
            n_checks++;
            if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
                n_fail++;
                $display("FAIL extreme_%0d: got lat=%0d sign=%0b prod=%0d, want lat=9 sign=%0b prod=%0d",
                         i, lat, o_sign, o_product, exp_v[16], exp_v[15:0]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        start_op(12, 10);
        sb.push_back({1'b0, 16'd120});
        repeat (3) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_multiplicand = 8'd3;
        i_multiplier = 8'd3;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_stop(4, lat);
        exp_v = sb.pop_front();
        n_checks++;
        if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
            n_fail++;
            $display("FAIL busy_ignore: got lat=%0d sign=%0b prod=%0d, want lat=9 sign=0 prod=120",
                     lat, o_sign, o_product);
        end
        start_op(3, 3);
        sb.push_back({1'b0, 16'd9});
        n_checks++;
        if (o_stop !== 1'b0 || o_product !== 16'd0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: got stop=%0b prod=%0d busy=%0b, want stop=0 prod=0 busy=1",
                     o_stop, o_product, o_busy);
        end
        wait_stop(0, lat);
        exp_v = sb.pop_front();
        n_checks++;
        if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
            n_fail++;
            $display("FAIL restart_result: got lat=%0d sign=%0b prod=%0d, want lat=9 sign=0 prod=9",
                     lat, o_sign, o_product);
        end
    endtask

    task automatic test_reset_mid;
        int stop_seen;
        start_op(100, 100);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_product, o_sign, o_stop, o_busy} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got prod=%0d sign=%0b stop=%0b busy=%0b, want all 0",
                     o_product, o_sign, o_stop, o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        stop_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (o_stop || o_busy) stop_seen++;
        end
        n_checks++;
        if (stop_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %0d cycles with stop/busy, want 0", stop_seen);
        end
        start_op(2, -2);
        sb.push_back({1'b1, 16'd4});
        wait_stop(0, lat);
        exp_v = sb.pop_front();
        n_checks++;
        if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_next: got lat=%0d sign=%0b prod=%0d, want lat=9 sign=1 prod=4",
                     lat, o_sign, o_product);
        end
    endtask

    task automatic test_back_to_back;
        i_start = 1'b1;
        i_multiplicand = 8'd4;
        i_multiplier = 8'd5;
        sb.push_back({1'b0, 16'd20});
        sb.push_back({1'b0, 16'd20});
        @(posedge clk);
        #1;
        wait_stop(0, lat);
        exp_v = sb.pop_front();
        n_checks++;
        if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
            n_fail++;
            $display("FAIL held_first: got lat=%0d sign=%0b prod=%0d, want lat=9 sign=0 prod=20",
                     lat, o_sign, o_product);
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
        n_checks++;
        if (o_stop !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_pulse: got stop=%0b busy=%0b, want stop=0 busy=1", o_stop, o_busy);
        end
        wait_stop(0, lat);
        exp_v = sb.pop_front();
        n_checks++;
        if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
            n_fail++;
            $display("FAIL held_second: got lat=%0d sign=%0b prod=%0d, want lat=9 sign=0 prod=20",
                     lat, o_sign, o_product);
        end
    endtask

    task automatic test_random;
        int a;
        int b;
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            start_op(a, b);
            sb.push_back(model(a, b));
            n_checks++;
            if (o_stop !== 1'b0 || o_product !== 16'd0) begin
                n_fail++;
                $display("FAIL rand_clear_%0d: got stop=%0b prod=%0d, want stop=0 prod=0",
                         i, o_stop, o_product);
            end
            wait_stop(0, lat);
            exp_v = sb.pop_front();
            n_checks++;
            if (lat !== 9 || {o_sign, o_product} !== exp_v) begin
                n_fail++;
                $display("FAIL rand_%0d: a=%0d b=%0d got lat=%0d sign=%0b prod=%0d, want lat=9 sign=%0b prod=%0d",
                         i, a, b, lat, o_sign, o_product, exp_v[16], exp_v[15:0]);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            n_checks++;
            if (o_stop !== 1'b1 || {o_sign, o_product} !== exp_v) begin
                n_fail++;
                $display("FAIL rand_hold_%0d: got stop=%0b sign=%0b prod=%0d, want stop=1 sign=%0b prod=%0d",
                         i, o_stop, o_sign, o_product, exp_v[16], exp_v[15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
